// File: rtl/counter_clock_downsample_pkg.sv
// Shared constants and types for the RGMII reference clock divider.
// Divide values assume a 250 MHz source clock.
package counter_clock_downsample_pkg;

    localparam int unsigned WIDTH_DEFAULT = 7;

    localparam int unsigned DIV_1G   = 0;
    localparam int unsigned DIV_100M = 4;
    localparam int unsigned DIV_10M  = 49;

    typedef enum logic [1:0] {
        SPEED_10M  = 2'b00,
        SPEED_100M = 2'b01,
        SPEED_1G   = 2'b10
    } speed_e;

    function automatic int unsigned speed_to_div(input speed_e speed);
        int unsigned div;
        case (speed)
            SPEED_1G:   div = DIV_1G;
            SPEED_100M: div = DIV_100M;
            default:    div = DIV_10M;
        endcase
        return div;
    endfunction

endpackage

// File: rtl/counter_clock_downsample_cnt.sv
// Half-period cycle counter: counts up to val_i, flags wrap_o and clears on the same edge.
module counter_clock_downsample_cnt
    import counter_clock_downsample_pkg::*;
#(
    parameter int width_p = WIDTH_DEFAULT
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic [width_p-1:0] val_i,
    output logic               wrap_o
);

    logic [width_p-1:0] cnt_reg;
    logic [width_p-1:0] cnt_next;

    // >= rather than == so a val_i lowered below the count ends the phase at once
    assign wrap_o = (cnt_reg >= val_i);

    always_comb begin
        cnt_next = cnt_reg + width_p'(1);
        if (wrap_o) begin
            cnt_next = '0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

endmodule

// File: rtl/counter_clock_downsample.sv
// Programmable 50%-duty clock divider; period of clk_r_o is 2*(val_i+1) clk_i cycles.
// Define COUNTER_CLOCK_DOWNSAMPLE_STROBE_EN to add the toggle_o strobe output.
module counter_clock_downsample
    import counter_clock_downsample_pkg::*;
#(
    parameter int width_p = WIDTH_DEFAULT
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic [width_p-1:0] val_i,
    output logic               clk_r_o
`ifdef COUNTER_CLOCK_DOWNSAMPLE_STROBE_EN
    ,
    output logic               toggle_o
`endif
);

    logic wrap;
    logic clk_r_reg;

    counter_clock_downsample_cnt #(
        .width_p (width_p)
    ) u_cnt (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .val_i     (val_i),
        .wrap_o    (wrap)
    );

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            clk_r_reg <= 1'b0;
        end else if (wrap) begin
            clk_r_reg <= ~clk_r_reg;
        end
    end

    assign clk_r_o = clk_r_reg;

`ifdef COUNTER_CLOCK_DOWNSAMPLE_STROBE_EN
    // Gated with reset so a zero val_i does not strobe while the counter is held
    assign toggle_o = wrap & reset_n_i;
`endif

endmodule

// File: tb/tb_counter_clock_downsample.sv
// Self-checking bench for counter_clock_downsample (width_p=7, 4 ns clock).
// The reference model tracks the cycle stamp of the last clk_r_o edge.
module tb_counter_clock_downsample;

    localparam int W = 7;

    logic         clk_i     = 1'b0;
    logic         reset_n_i = 1'b0;
    logic [W-1:0] val_i     = '0;
    logic         clk_r_o;
`ifdef COUNTER_CLOCK_DOWNSAMPLE_STROBE_EN
    logic         toggle_o;
`endif

    int   checks = 0;
    int   errors = 0;

    // Model: posedges since reset release, and the posedge index where the current phase began
    int   m_cycle;
    int   m_phase_start;
    logic m_clk;

    counter_clock_downsample #(
        .width_p (W)
    ) dut (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .val_i     (val_i),
        .clk_r_o   (clk_r_o)
`ifdef COUNTER_CLOCK_DOWNSAMPLE_STROBE_EN
        ,
        .toggle_o  (toggle_o)
`endif
    );

    always #2 clk_i = ~clk_i;

    // A phase ends on the edge where it has already lasted val_i+1 cycles (or more, after a decrease)
    function automatic logic m_phase_done();
        return (m_cycle - m_phase_start) >= int'(val_i);
    endfunction

    task automatic model_reset();
        m_cycle       = 0;
        m_phase_start = 0;
        m_clk         = 1'b0;
    endtask

    task automatic tick();
        if (m_phase_done()) begin
            m_clk         = ~m_clk;
            m_phase_start = m_cycle + 1;
        end
        m_cycle++;
        @(posedge clk_i);
        #1;
    endtask

    task automatic apply_reset();
        reset_n_i = 1'b0;
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        reset_n_i = 1'b1;
    endtask

    task automatic test_reset();
        reset_n_i = 1'b0;
        val_i     = '0;
        repeat (3) begin
            @(posedge clk_i);
            #1;
            checks++;
            if (clk_r_o !== 1'b0) begin
                errors++;
                $display("FAIL reset_clk got %b want 0", clk_r_o);
            end
`ifdef COUNTER_CLOCK_DOWNSAMPLE_STROBE_EN
            checks++;
            if (toggle_o !== 1'b0) begin
                errors++;
                $display("FAIL reset_toggle got %b want 0", toggle_o);
            end
`endif
        end
        $display("test_reset: outputs held low for 3 cycles with val_i=0");
    endtask

    task automatic test_divide(input int v, input int n);
        logic prev;
        logic first_seen;
        int   last_rise;
        val_i = W'(v);
        apply_reset();
        prev       = 1'b0;
        first_seen = 1'b0;
        last_rise  = 0;
        for (int k = 1; k <= n; k++) begin
            tick();
            checks++;
            if (clk_r_o !== m_clk) begin
                errors++;
                $display("FAIL divide%0d_clk cycle %0d got %b want %b", v, k, clk_r_o, m_clk);
            end
`ifdef COUNTER_CLOCK_DOWNSAMPLE_STROBE_EN
            checks++;
            if (toggle_o !== m_phase_done()) begin
                errors++;
                $display("FAIL divide%0d_toggle cycle %0d got %b want %b", v, k, toggle_o, m_phase_done());
            end
`endif
            if (!prev && clk_r_o) begin
                checks++;
                if (!first_seen && k != v + 1) begin
                    errors++;
                    $display("FAIL divide%0d_first_rise got cycle %0d want %0d", v, k, v + 1);
                end else if (first_seen && (k - last_rise) != 2 * (v + 1)) begin
                    errors++;
                    $display("FAIL divide%0d_period got %0d want %0d", v, k - last_rise, 2 * (v + 1));
                end
                first_seen = 1'b1;
                last_rise  = k;
            end
            prev = clk_r_o;
        end
        checks++;
        if (!first_seen) begin
            errors++;
            $display("FAIL divide%0d_no_rise got none want rise at %0d", v, v + 1);
        end
        $display("test_divide: val_i=%0d ran %0d cycles, expected period %0d", v, n, 2 * (v + 1));
    endtask

    task automatic test_switch();
        val_i = W'(49);
        apply_reset();
        for (int k = 1; k <= 20; k++) begin
            tick();
            checks++;
            if (clk_r_o !== m_clk) begin
                errors++;
                $display("FAIL switch_pre cycle %0d got %b want %b", k, clk_r_o, m_clk);
            end
        end
        val_i = W'(4);
        tick();
        checks++;
        if (clk_r_o !== 1'b1) begin
            errors++;
            $display("FAIL switch_immediate_toggle got %b want 1", clk_r_o);
        end
        for (int k = 1; k <= 40; k++) begin
            tick();
            checks++;
            if (clk_r_o !== m_clk) begin
                errors++;
                $display("FAIL switch_post cycle %0d got %b want %b", k, clk_r_o, m_clk);
            end
        end
        $display("test_switch: val_i 49->4 at count 20, toggled next edge, then period 10");
    endtask

    task automatic test_async_reset();
        val_i = W'(4);
        apply_reset();
        repeat (7) tick();
        checks++;
        if (clk_r_o !== 1'b1) begin
            errors++;
            $display("FAIL async_pre_high got %b want 1", clk_r_o);
        end
        reset_n_i = 1'b0;
        #1;
        checks++;
        if (clk_r_o !== 1'b0) begin
            errors++;
            $display("FAIL async_drop got %b want 0", clk_r_o);
        end
        model_reset();
        @(negedge clk_i);
        reset_n_i = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            checks++;
            if (clk_r_o !== (k == 5)) begin
                errors++;
                $display("FAIL async_rerise cycle %0d got %b want %b", k, clk_r_o, (k == 5));
            end
        end
        $display("test_async_reset: mid-high reset dropped clk_r_o, first rise at 5th edge");
    endtask

    task automatic test_random();
        int changes;
        changes = 0;
        val_i = W'($urandom_range(0, 15));
        apply_reset();
        for (int k = 1; k <= 1500; k++) begin
            tick();
            checks++;
            if (clk_r_o !== m_clk) begin
                errors++;
                $display("FAIL random_clk cycle %0d val %0d got %b want %b", k, val_i, clk_r_o, m_clk);
            end
`ifdef COUNTER_CLOCK_DOWNSAMPLE_STROBE_EN
            checks++;
            if (toggle_o !== m_phase_done()) begin
                errors++;
                $display("FAIL random_toggle cycle %0d got %b want %b", k, toggle_o, m_phase_done());
            end
`endif
            if ($urandom_range(0, 19) == 0) begin
                if ($urandom_range(0, 3) == 0) begin
                    val_i = W'($urandom_range(0, (1 << W) - 1));
                end else begin
                    val_i = W'($urandom_range(0, 15));
                end
                changes++;
            end
        end
        $display("test_random: 1500 cycles with %0d random val_i changes", changes);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_divide(0, 40);
        test_divide(4, 100);
        test_divide(49, 450);
        test_divide(127, 800);
        test_switch();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
